// File: rtl/bit_serial_matvec_if.sv
// Request/response bundle for the bit-serial matrix-vector multiplier.
// The master drives the operands and start; the slave returns the status flags and the results.
interface bit_serial_matvec_if #(
    parameter int N_IN       = 10,
    parameter int N_OUT      = 15,
    parameter int WIDTH      = 32,
    parameter int COEF_WIDTH = 8,
    parameter int OUT_WIDTH  = 32
);
    logic                                       start;
    logic [N_IN-1:0][WIDTH-1:0]                 values;
    logic [N_OUT-1:0][N_IN-1:0][COEF_WIDTH-1:0] coefs;
    logic                                       busy;
    logic                                       done;
    logic [N_OUT-1:0][OUT_WIDTH-1:0]            result;

    modport master (output start, values, coefs, input busy, done, result);
    modport slave  (input start, values, coefs, output busy, done, result);
endinterface

// File: rtl/bit_serial_matvec.sv
// Bit-serial matrix-vector multiplier: result[j] = sum_i coefs[j][i]*values[i].
// Each cycle consumes one value bit-plane (LSB first), with one accumulator lane per output row.
module bit_serial_matvec_row #(
    parameter int N_IN       = 10,
    parameter int COEF_WIDTH = 8,
    parameter int OUT_WIDTH  = 32,
    parameter int SIGNED     = 1,
    parameter int BW         = 5
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clr,
    input  logic                            en,
    input  logic                            last,
    input  logic [BW-1:0]                   b,
    input  logic [N_IN-1:0]                 plane,
    input  logic [N_IN-1:0][COEF_WIDTH-1:0] coef,
    output logic [OUT_WIDTH-1:0]            result
);
    localparam int PW = COEF_WIDTH + $clog2(N_IN) + 1;
    localparam int AW = (OUT_WIDTH > PW) ? OUT_WIDTH : PW;

    logic signed [PW-1:0] p;
    logic [AW-1:0]        term, acc, acc_nxt;

    always_comb begin
        p = '0;
        for (int i = 0; i < N_IN; i++)
            if (plane[i]) p = p + PW'($signed(coef[i]));
        term = AW'(p) << b;
        // In signed mode the value MSB has weight -2^(WIDTH-1).
        if (SIGNED != 0 && last) acc_nxt = acc - term;
        else                     acc_nxt = acc + term;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            result <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_nxt;
            if (last) result <= acc_nxt[OUT_WIDTH-1:0];
        end
    end
endmodule

module bit_serial_matvec #(
    parameter int N_IN       = 10,
    parameter int N_OUT      = 15,
    parameter int WIDTH      = 32,
    parameter int COEF_WIDTH = 8,
    parameter int OUT_WIDTH  = 32,
    parameter int SIGNED     = 1
) (
    input logic                clk,
    input logic                rst,
    bit_serial_matvec_if.slave bus
);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                                     state, state_nxt;
    logic                                       accept, last, run;
    logic [BW-1:0]                              bcnt;
    logic [N_IN-1:0][WIDTH-1:0]                 vals_q;
    logic [N_OUT-1:0][N_IN-1:0][COEF_WIDTH-1:0] coefs_q;
    logic [N_IN-1:0]                            plane;
    logic [N_OUT-1:0][OUT_WIDTH-1:0]            res;
    logic                                       busy_q, done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: if (bus.start) begin
                accept    = 1'b1;
                state_nxt = RUN;
            end
            RUN: if (bcnt == BW'(WIDTH - 1)) begin
                last      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign run = (state == RUN);

    // Shadow values shift right each cycle, so bit 0 is always the current plane.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt    <= '0;
            vals_q  <= '0;
            coefs_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            busy_q <= (state_nxt == RUN);
            done_q <= last;
            if (accept) begin
                vals_q  <= bus.values;
                coefs_q <= bus.coefs;
                bcnt    <= '0;
            end else if (run) begin
                bcnt <= bcnt + BW'(1);
                for (int i = 0; i < N_IN; i++) vals_q[i] <= vals_q[i] >> 1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_IN; i++) plane[i] = vals_q[i][0];
    end

    for (genvar j = 0; j < N_OUT; j++) begin : g_row
        bit_serial_matvec_row #(
            .N_IN(N_IN), .COEF_WIDTH(COEF_WIDTH), .OUT_WIDTH(OUT_WIDTH),
            .SIGNED(SIGNED), .BW(BW)
        ) u_row (
            .clk(clk), .rst(rst), .clr(accept), .en(run), .last(last), .b(bcnt),
            .plane(plane), .coef(coefs_q[j]), .result(res[j])
        );
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = res;
endmodule

// File: tb/tb_bit_serial_matvec.sv
// Directed and randomised checks of bit_serial_matvec in several configurations.
module tb_bit_serial_matvec;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    bit_serial_matvec_if ia ();
    bit_serial_matvec_if #(.OUT_WIDTH(40)) ib ();
    bit_serial_matvec_if #(.OUT_WIDTH(40)) ic ();
    bit_serial_matvec_if #(.N_IN(4), .N_OUT(3), .WIDTH(12), .COEF_WIDTH(5), .OUT_WIDTH(16)) id ();
    bit_serial_matvec_if #(.N_IN(4), .N_OUT(3), .WIDTH(12), .COEF_WIDTH(5), .OUT_WIDTH(16)) ie ();

    bit_serial_matvec dut_a (.clk(clk), .rst(rst), .bus(ia));
    bit_serial_matvec #(.OUT_WIDTH(40), .SIGNED(1)) dut_b (.clk(clk), .rst(rst), .bus(ib));
    bit_serial_matvec #(.OUT_WIDTH(40), .SIGNED(0)) dut_c (.clk(clk), .rst(rst), .bus(ic));
    bit_serial_matvec #(.N_IN(4), .N_OUT(3), .WIDTH(12), .COEF_WIDTH(5), .OUT_WIDTH(16), .SIGNED(1))
        dut_d (.clk(clk), .rst(rst), .bus(id));
    bit_serial_matvec #(.N_IN(4), .N_OUT(3), .WIDTH(12), .COEF_WIDTH(5), .OUT_WIDTH(16), .SIGNED(0))
        dut_e (.clk(clk), .rst(rst), .bus(ie));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic sel_done(input int w);
        case (w)
            0:       return ia.done;
            1:       return ib.done;
            default: return id.done;
        endcase
    endfunction

    task automatic wait_done(input int w, output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!sel_done(w) && lat < 100);
    endtask

    task automatic load_t1;
        ia.values    = '0;
        ia.values[0] = 32'd1;   ia.values[1] = 32'd3;  ia.values[2] = 32'd5;
        ia.values[3] = 32'd19;  ia.values[4] = 32'd24; ia.values[5] = 32'd12;
        ia.values[6] = 32'd23;  ia.values[7] = 32'd135;
        ia.values[8] = 32'hFFFFFFE9; ia.values[9] = 32'd20;
        ia.coefs = '0;
        for (int i = 0; i < 10; i++) ia.coefs[0][i] = 8'd1;
        ia.coefs[1][8] = 8'hFF;
        ia.coefs[2][7] = 8'd2;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #2;
        checks++; if (ia.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", ia.busy); end
        checks++; if (ia.done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", ia.done); end
        checks++; if (ia.result !== '0) begin errors++; $display("FAIL reset_result got %0h want 0", ia.result); end
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int lat;
        load_t1();
        ia.start = 1'b1; tick(); ia.start = 1'b0;
        checks++; if (ia.busy !== 1'b1) begin errors++; $display("FAIL basic_busy_rise got %0b want 1", ia.busy); end
        wait_done(0, lat);
        checks++; if (lat !== 32) begin errors++; $display("FAIL basic_latency got %0d want 32", lat); end
        checks++; if (ia.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got %0b want 0", ia.busy); end
        checks++; if (ia.result[0] !== 32'd219) begin errors++; $display("FAIL basic_r0 got %0d want 219", ia.result[0]); end
        checks++; if (ia.result[1] !== 32'd23) begin errors++; $display("FAIL basic_r1 got %0d want 23", ia.result[1]); end
        checks++; if (ia.result[2] !== 32'd270) begin errors++; $display("FAIL basic_r2 got %0d want 270", ia.result[2]); end
        for (int j = 3; j < 15; j++) begin
            checks++;
            if (ia.result[j] !== 32'd0) begin errors++; $display("FAIL basic_r%0d got %0d want 0", j, ia.result[j]); end
        end
        tick();
        checks++; if (ia.done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %0b want 0", ia.done); end
    endtask

    task automatic test_sign_mode;
        int lat;
        ib.values = '0; ib.coefs = '0;
        ib.values[0] = 32'hFFFFFFE9; ib.coefs[0][0] = 8'd1;
        ic.values = ib.values; ic.coefs = ib.coefs;
        ib.start = 1'b1; ic.start = 1'b1; tick(); ib.start = 1'b0; ic.start = 1'b0;
        wait_done(1, lat);
        checks++; if (ic.done !== 1'b1) begin errors++; $display("FAIL sign_udone got %0b want 1", ic.done); end
        checks++; if (ib.result[0] !== 40'hFFFFFFFFE9) begin errors++; $display("FAIL sign_signed got %0h want ffffffffe9", ib.result[0]); end
        checks++; if (ic.result[0] !== 40'h00FFFFFFE9) begin errors++; $display("FAIL sign_unsigned got %0h want ffffffe9", ic.result[0]); end
    endtask

    task automatic test_extremes;
        int lat;
        ib.coefs = '0;
        for (int i = 0; i < 10; i++) begin ib.values[i] = 32'hFFFFFFFF; ib.coefs[0][i] = 8'h80; end
        ib.start = 1'b1; tick(); ib.start = 1'b0;
        wait_done(1, lat);
        checks++; if (ib.result[0] !== 40'd1280) begin errors++; $display("FAIL ext_all_neg got %0d want 1280", ib.result[0]); end
        ib.values = '0; ib.coefs = '0;
        ib.values[0] = 32'h80000000; ib.coefs[0][0] = 8'h80;
        ib.start = 1'b1; tick(); ib.start = 1'b0;
        wait_done(1, lat);
        checks++; if (ib.result[0] !== 40'h4000000000) begin errors++; $display("FAIL ext_min_min got %0h want 4000000000", ib.result[0]); end
        checks++; if (ib.result[1] !== 40'd0) begin errors++; $display("FAIL ext_row1 got %0h want 0", ib.result[1]); end
    endtask

    task automatic test_handshake;
        int n_done, first_done, lat;
        logic stable;
        n_done = 0; first_done = 0; stable = 1'b1;
        load_t1();
        ia.start = 1'b1; tick();
        for (int cyc = 1; cyc <= 32; cyc++) begin
            ia.start = (cyc == 5 || cyc == 20 || cyc >= 30);
            if (cyc == 5) begin
                for (int i = 0; i < 10; i++) begin ia.values[i] = $urandom; ia.coefs[0][i] = 8'($urandom); end
            end
            if (cyc == 30) begin load_t1(); ia.values[9] = 32'd120; end
            tick();
            if (ia.done === 1'b1) begin n_done++; if (first_done == 0) first_done = cyc; end
        end
        checks++; if (n_done !== 1) begin errors++; $display("FAIL hs_done_count got %0d want 1", n_done); end
        checks++; if (first_done !== 32) begin errors++; $display("FAIL hs_done_cycle got %0d want 32", first_done); end
        checks++; if (ia.result[0] !== 32'd219) begin errors++; $display("FAIL hs_first_r0 got %0d want 219", ia.result[0]); end
        tick(); ia.start = 1'b0;
        checks++; if (ia.done !== 1'b0 || ia.busy !== 1'b1) begin errors++; $display("FAIL hs_b2b_flags got done=%0b busy=%0b want done=0 busy=1", ia.done, ia.busy); end
        lat = 0;
        do begin
            if (ia.result[0] !== 32'd219) stable = 1'b0;
            tick(); lat++;
        end while (!ia.done && lat < 100);
        checks++; if (stable !== 1'b1) begin errors++; $display("FAIL hs_result_held got %0b want 1", stable); end
        checks++; if (lat !== 32) begin errors++; $display("FAIL hs_b2b_latency got %0d want 32", lat); end
        checks++; if (ia.result[0] !== 32'd319) begin errors++; $display("FAIL hs_second_r0 got %0d want 319", ia.result[0]); end
    endtask

    task automatic test_reset_mid;
        int lat;
        load_t1();
        ia.start = 1'b1; tick(); ia.start = 1'b0;
        repeat (16) tick();
        rst = 1'b1;
        #1;
        checks++; if (ia.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %0b want 0", ia.busy); end
        checks++; if (ia.done !== 1'b0) begin errors++; $display("FAIL rmid_done got %0b want 0", ia.done); end
        checks++; if (ia.result !== '0) begin errors++; $display("FAIL rmid_result got %0h want 0", ia.result); end
        tick(); tick();
        rst = 1'b0;
        ia.start = 1'b1; tick(); ia.start = 1'b0;
        wait_done(0, lat);
        checks++; if (lat !== 32) begin errors++; $display("FAIL rmid_latency got %0d want 32", lat); end
        checks++; if (ia.result[0] !== 32'd219) begin errors++; $display("FAIL rmid_r0 got %0d want 219", ia.result[0]); end
        checks++; if (ia.result[2] !== 32'd270) begin errors++; $display("FAIL rmid_r2 got %0d want 270", ia.result[2]); end
    endtask

    task automatic test_random;
        logic [3:0][11:0]     v;
        logic [2:0][3:0][4:0] c;
        logic [2:0][15:0]     exp_s, exp_u;
        int ci, ss, su, lat;
        for (int n = 0; n < 1000; n++) begin
            for (int i = 0; i < 4; i++) begin
                v[i] = (n == 0) ? 12'h800 : 12'($urandom);
                for (int j = 0; j < 3; j++) c[j][i] = (n == 0) ? 5'h10 : 5'($urandom);
            end
            for (int j = 0; j < 3; j++) begin
                ss = 0; su = 0;
                for (int i = 0; i < 4; i++) begin
                    ci = {{27{c[j][i][4]}}, c[j][i]};
                    ss += ci * int'({{20{v[i][11]}}, v[i]});
                    su += ci * int'({20'b0, v[i]});
                end
                exp_s[j] = ss[15:0];
                exp_u[j] = su[15:0];
            end
            id.values = v; ie.values = v; id.coefs = c; ie.coefs = c;
            id.start = 1'b1; ie.start = 1'b1; tick(); id.start = 1'b0; ie.start = 1'b0;
            lat = 0;
            do begin
                id.values = $urandom; ie.values = $urandom;
                id.coefs = 60'($urandom); ie.coefs = 60'($urandom);
                tick(); lat++;
            end while (!id.done && lat < 100);
            checks++; if (lat !== 12) begin errors++; $display("FAIL rnd%0d_latency got %0d want 12", n, lat); end
            checks++; if (ie.done !== 1'b1) begin errors++; $display("FAIL rnd%0d_udone got %0b want 1", n, ie.done); end
            for (int j = 0; j < 3; j++) begin
                checks++;
                if (id.result[j] !== exp_s[j]) begin errors++; $display("FAIL rnd%0d_signed_r%0d got %0h want %0h", n, j, id.result[j], exp_s[j]); end
                checks++;
                if (ie.result[j] !== exp_u[j]) begin errors++; $display("FAIL rnd%0d_unsigned_r%0d got %0h want %0h", n, j, ie.result[j], exp_u[j]); end
            end
        end
    endtask

    initial begin
        ia.start = 1'b0; ib.start = 1'b0; ic.start = 1'b0; id.start = 1'b0; ie.start = 1'b0;
        ia.values = '0; ib.values = '0; ic.values = '0; id.values = '0; ie.values = '0;
        ia.coefs = '0; ib.coefs = '0; ic.coefs = '0; id.coefs = '0; ie.coefs = '0;
        test_reset();
        test_basic();
        test_sign_mode();
        test_extremes();
        test_handshake();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
